// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes,
// opcodes and datapath select codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Datapath strobe/select bundle produced by the controller decode.
interface mips_multicycle_control_if;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;

    modport master (
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src
    );
    modport slave (
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src
    );
endinterface

// File: rtl/mips_mc_decode.sv
// Moore output decode of the controller state; only FETCH looks at mem_ready.
module mips_mc_decode
    import mips_mc_pkg::*;
(
    input  state_t                           state,
    input  logic                             mem_ready,
    mips_multicycle_control_if.master        ctl
);

    always_comb begin
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.iord          = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_ADD;
        ctl.pc_src        = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: ctl.alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl.pc_write_cond = 1'b1;
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_src        = PCSRC_OUT;
            end
            S_ADDIWB: ctl.reg_write = 1'b1;
            S_JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with retired-instruction counter; output
// decode lives in mips_mc_decode.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_inc;
    logic             illegal_dec;

    mips_multicycle_control_if ctl ();

    mips_mc_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctl       (ctl)
    );

    always_comb begin
        state_d     = state_q;
        retire_inc  = 1'b0;
        illegal_dec = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_dec = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d    = S_FETCH;
                    retire_inc = 1'b1;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d    = S_FETCH;
                retire_inc = 1'b1;
            end
            default:   state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire_inc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Architectural write strobes are held off while reset is low, whatever state is held.
    assign pc_write      = ctl.pc_write      & reset;
    assign pc_write_cond = ctl.pc_write_cond & reset;
    assign ir_write      = ctl.ir_write      & reset;
    assign reg_write     = ctl.reg_write     & reset;
    assign mem_write     = ctl.mem_write     & reset;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_dst       = ctl.reg_dst;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign pc_src        = ctl.pc_src;
    assign illegal_op    = illegal_dec & reset;
    assign state         = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: driver pushes hand-computed per-cycle expectations,
// monitor pops and compares on every falling edge.
module tb_mips_multicycle_control;
    import mips_mc_pkg::*;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] vec;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state, state4;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  retired4;

    logic        n_pw, n_pwc, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rd, n_rw, n_asa, n_ill;
    logic [1:0]  n_asb, n_aop, n_pcs;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_src        = pc_src;

    mips_multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    mips_multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pw), .pc_write_cond(n_pwc), .iord(n_iord),
        .mem_read(n_mr), .mem_write(n_mw), .ir_write(n_irw),
        .mem_to_reg(n_m2r), .reg_dst(n_rd), .reg_write(n_rw),
        .alu_src_a(n_asa), .alu_src_b(n_asb), .alu_op(n_aop),
        .pc_src(n_pcs), .state(state4), .illegal_op(n_ill), .retired(retired4)
    );

    // vec bits: pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,
    // mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0]
    function automatic logic [15:0] exp_vec(input logic [3:0] st, input logic mr, input logic rst);
        logic [15:0] v;
        case (st)
            4'd0:    v = mr ? 16'h9410 : 16'h1010;
            4'd1:    v = 16'h0030;
            4'd2:    v = 16'h0060;
            4'd3:    v = 16'h3000;
            4'd4:    v = 16'h0280;
            4'd5:    v = 16'h2800;
            4'd6:    v = 16'h0048;
            4'd7:    v = 16'h0180;
            4'd8:    v = 16'h4045;
            4'd9:    v = 16'h0060;
            4'd10:   v = 16'h0080;
            4'd11:   v = 16'h8002;
            default: v = 16'h0000;
        endcase
        if (!rst) v = v & 16'h337F;
        return v;
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic ill, input logic [31:0] ret);
        exp_t e;
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        e.st  = st;
        e.vec = exp_vec(st, mr, rst);
        e.ill = ill;
        e.ret = ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] v;
            e = sb.pop_front();
            v = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                 bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                 bus.alu_src_b, bus.alu_op, bus.pc_src};
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'(v), 32'(e.vec));
            check("illegal_op", 32'(illegal_op), 32'(e.ill));
            check("retired", retired, e.ret);
            check("state_w4", 32'(state4), 32'(e.st));
            check("retired_w4", 32'(retired4), {28'd0, e.ret[3:0]});
        end
    end

    initial begin
        reset = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1;
        @(posedge clk); #1;
        step(1'b0, OP_RTYPE, 1'b1, S_FETCH, 1'b0, 0);
        // R-type
        step(1'b1, OP_RTYPE, 1'b1, S_FETCH,   1'b0, 0);
        step(1'b1, OP_RTYPE, 1'b1, S_DECODE,  1'b0, 0);
        step(1'b1, OP_RTYPE, 1'b1, S_EXECUTE, 1'b0, 0);
        step(1'b1, OP_RTYPE, 1'b1, S_ALUWB,   1'b0, 0);
        // lw with two wait cycles
        step(1'b1, OP_LW, 1'b1, S_FETCH,  1'b0, 1);
        step(1'b1, OP_LW, 1'b1, S_DECODE, 1'b0, 1);
        step(1'b1, OP_LW, 1'b1, S_MEMADR, 1'b0, 1);
        step(1'b1, OP_LW, 1'b0, S_MEMRD,  1'b0, 1);
        step(1'b1, OP_LW, 1'b0, S_MEMRD,  1'b0, 1);
        step(1'b1, OP_LW, 1'b1, S_MEMRD,  1'b0, 1);
        step(1'b1, OP_LW, 1'b1, S_MEMWB,  1'b0, 1);
        // beq, with one fetch wait first
        step(1'b1, OP_BEQ, 1'b0, S_FETCH,  1'b0, 2);
        step(1'b1, OP_BEQ, 1'b1, S_FETCH,  1'b0, 2);
        step(1'b1, OP_BEQ, 1'b1, S_DECODE, 1'b0, 2);
        step(1'b1, OP_BEQ, 1'b1, S_BRANCH, 1'b0, 2);
        // illegal opcode
        step(1'b1, 6'h3F, 1'b1, S_FETCH,  1'b0, 3);
        step(1'b1, 6'h3F, 1'b1, S_DECODE, 1'b1, 3);
        // addi
        step(1'b1, OP_ADDI, 1'b1, S_FETCH,  1'b0, 3);
        step(1'b1, OP_ADDI, 1'b1, S_DECODE, 1'b0, 3);
        step(1'b1, OP_ADDI, 1'b1, S_ADDIEX, 1'b0, 3);
        step(1'b1, OP_ADDI, 1'b1, S_ADDIWB, 1'b0, 3);
        // sw, no wait
        step(1'b1, OP_SW, 1'b1, S_FETCH,  1'b0, 4);
        step(1'b1, OP_SW, 1'b1, S_DECODE, 1'b0, 4);
        step(1'b1, OP_SW, 1'b1, S_MEMADR, 1'b0, 4);
        step(1'b1, OP_SW, 1'b1, S_MEMWR,  1'b0, 4);
        // sw abandoned by reset during the memory wait
        step(1'b1, OP_SW, 1'b1, S_FETCH,  1'b0, 5);
        step(1'b1, OP_SW, 1'b1, S_DECODE, 1'b0, 5);
        step(1'b1, OP_SW, 1'b1, S_MEMADR, 1'b0, 5);
        step(1'b1, OP_SW, 1'b0, S_MEMWR,  1'b0, 5);
        step(1'b1, OP_SW, 1'b0, S_MEMWR,  1'b0, 5);
        step(1'b0, OP_SW, 1'b0, S_MEMWR,  1'b0, 5);
        // 16 back-to-back jumps from a cleared counter
        for (int i = 0; i < 16; i++) begin
            step(1'b1, OP_J, 1'b1, S_FETCH,  1'b0, 32'(i));
            step(1'b1, OP_J, 1'b1, S_DECODE, 1'b0, 32'(i));
            step(1'b1, OP_J, 1'b1, S_JUMP,   1'b0, 32'(i));
        end
        step(1'b1, OP_J, 1'b0, S_FETCH, 1'b0, 16);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction register bits [31:26].
REQ-005 SHALL have port mem_ready  input  1  unified memory completes the current read/write this cycle.
REQ-006 SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each 1 bit: the datapath strobes and selects.
REQ-007 SHALL have outputs alu_src_b (2 bits), alu_op (2 bits) and pc_src (2 bits): the datapath selects.
REQ-008 SHALL have port state  output  4  current state encoding.
REQ-009 SHALL have port illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have port retired  output  CNT_W  count of completed instructions.

Function
REQ-011 SHALL implement a registered FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL return to FETCH.
REQ-012 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00, and SHALL hold while mem_ready=0.
REQ-013 FETCH SHALL assert ir_write and pc_write only in the mem_ready=1 cycle, then go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00.
REQ-015 DECODE SHALL branch on opcode: 0x23/0x2B->MEMADR, 0x00->EXECUTE, 0x04->BRANCH, 0x08->ADDIEX, 0x02->JUMP; any other opcode SHALL pulse illegal_op and go to FETCH without counting.
REQ-016 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00; MEMADR SHALL go to MEMRD (0x23) or MEMWR (0x2B), and ADDIEX SHALL go to ADDIWB.
REQ-017 MEMRD SHALL assert mem_read=1 and iord=1, holding until mem_ready=1, then go to MEMWB.
REQ-018 MEMWR SHALL assert mem_write=1 and iord=1, holding until mem_ready=1, then go to FETCH.
REQ-019 MEMWB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=1.
REQ-020 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to ALUWB.
REQ-021 ALUWB SHALL assert reg_write=1, reg_dst=1 and mem_to_reg=0.
REQ-022 ADDIWB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=0.
REQ-023 BRANCH SHALL assert pc_write_cond=1 with alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=01.
REQ-024 JUMP SHALL assert pc_write=1 with pc_src=10.
REQ-025 MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL each go to FETCH after one cycle.
REQ-026 Outputs SHALL be Moore decodes of state, except ir_write/pc_write in FETCH and illegal_op, which also depend on mem_ready/opcode.
REQ-027 Every output not listed for a state SHALL be 0.
REQ-028 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, ADDIWB, BRANCH or JUMP, wrapping from all-ones to 0.
REQ-029 Latency in cycles with zero memory wait SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each mem_ready=0 cycle SHALL add one.

Reset
REQ-030 While reset=0 at a clk edge: state SHALL load FETCH, retired SHALL load 0 and illegal_op SHALL be 0.
REQ-031 While reset=0, pc_write, pc_write_cond, ir_write, reg_write and mem_write SHALL be forced to 0.
REQ-032 Reset asserted mid-instruction, including a pending memory wait, SHALL abandon the instruction without incrementing retired.

Structure
REQ-033 State codes, opcode constants and alu_op codes SHALL live in shared package mips_mc_pkg.
REQ-034 Output decode SHALL be one sub-module mips_mc_decode (state, mem_ready -> strobes); the FSM and counter SHALL stay in the top.

Verification
REQ-035 Bench SHALL check: reset=0 for 2 cycles, then 1, opcode=0x00, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7; retired=1.
REQ-036 Bench SHALL check: lw (0x23) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 in all three state-3 cycles; retired +1.
REQ-037 Bench SHALL check: beq (0x04) -> pc_write_cond=1, pc_src=01 in state 8 only; total 3 cycles.
REQ-038 Bench SHALL check: opcode 0x3F -> illegal_op=1 for exactly the DECODE cycle; next state 0; retired unchanged.
REQ-039 Bench SHALL check: reset=0 asserted during the MEMWR wait -> next state 0, mem_write=0, retired=0.
REQ-040 Bench SHALL check: CNT_W=4 with 16 back-to-back j (0x02) instructions -> retired wraps 15 to 0.
